// File: rtl/loader_pkg.sv
// Shared definitions for the instruction-memory boot loader.
package loader_pkg;

  typedef enum logic [2:0] {
    ST_LEN_HI,
    ST_LEN_LO,
    ST_DATA,
    ST_WRITE,
    ST_CHECK,
    ST_DONE,
    ST_ERROR
  } state_t;

  localparam int unsigned LEN_BYTES      = 2;
  localparam int unsigned BYTES_PER_WORD = 4;

  // States in which the loader takes a byte from the stream.
  function automatic logic accepts_bytes(input state_t s);
    return (s == ST_LEN_HI) || (s == ST_LEN_LO) || (s == ST_DATA) || (s == ST_CHECK);
  endfunction

endpackage

// File: rtl/loader_word_assembler.sv
// Big-endian byte-to-word assembler: shifts bytes in MSB first and flags
// the byte that completes a word.
module loader_word_assembler
  import loader_pkg::*;
(
  input  logic        clock,
  input  logic        clear,
  input  logic        flush,
  input  logic        shift,
  input  logic [7:0]  byte_data,
  output logic [31:0] word,
  output logic        word_complete
);

  localparam int unsigned CNT_W = $clog2(BYTES_PER_WORD);

  logic [CNT_W-1:0] count;

  assign word_complete = shift && (count == CNT_W'(BYTES_PER_WORD - 1));

  // Shift register and modulo-4 byte counter.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      word  <= '0;
      count <= '0;
    end else if (flush) begin
      count <= '0;
    end else if (shift) begin
      word  <= {word[23:0], byte_data};
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: receives a length-prefixed byte stream, writes big-endian
// words to instruction memory from word 0 and holds the CPU in clear until
// the image is complete. Define LOADER_CHECKSUM_EN to require a trailing
// checksum byte (8-bit sum of the whole stream must be zero).
module imem_loader
  import loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        mem_write,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        cpu_clear,
  output logic        done,
  output logic        error
);

  localparam int unsigned IDX_W = ADDR_WIDTH + 1;
  localparam int unsigned LEN_W = 8 * LEN_BYTES;
  localparam logic [LEN_W:0] MAX_WORDS = (LEN_W + 1)'(2 ** ADDR_WIDTH);

  state_t             state;
  state_t             state_next;
  logic [LEN_W-1:0]   len;
  logic [LEN_W-1:0]   len_full;
  logic [IDX_W-1:0]   word_index;
  logic [IDX_W-1:0]   index_next;
  logic               last_word;
  logic               accept;
  logic               restart;
  logic               word_complete;
  logic [31:0]        word;
  logic               csum_ok;

`ifdef LOADER_CHECKSUM_EN
  localparam state_t ST_AFTER_IMAGE = ST_CHECK;
  logic [7:0] csum;
  logic [7:0] csum_final;

  assign csum_final = csum + byte_data;
  assign csum_ok    = (csum_final == 8'h00);

  // Running 8-bit sum of every accepted stream byte.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      csum <= '0;
    end else if (restart) begin
      csum <= '0;
    end else if (accept) begin
      csum <= csum_final;
    end
  end
`else
  localparam state_t ST_AFTER_IMAGE = ST_DONE;
  assign csum_ok = 1'b1;
`endif

  assign accept     = byte_valid && byte_ready;
  assign restart    = start && ((state == ST_DONE) || (state == ST_ERROR));
  assign len_full   = {len[LEN_W-1:8], byte_data};
  assign index_next = word_index + 1'b1;
  assign last_word  = ((LEN_W + 1)'(index_next) == {1'b0, len});

  assign mem_address    = 32'({word_index, 2'b00});
  assign mem_write_data = word;

  loader_word_assembler u_assembler (
    .clock         (clock),
    .clear         (clear),
    .flush         (restart),
    .shift         (accept && (state == ST_DATA)),
    .byte_data     (byte_data),
    .word          (word),
    .word_complete (word_complete)
  );

  // State register.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state <= ST_LEN_HI;
    end else begin
      state <= state_next;
    end
  end

  // Length register and word index.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      len        <= '0;
      word_index <= '0;
    end else if (restart) begin
      len        <= '0;
      word_index <= '0;
    end else begin
      if (accept && (state == ST_LEN_HI)) len[LEN_W-1:8] <= byte_data;
      if (accept && (state == ST_LEN_LO)) len[7:0]       <= byte_data;
      if (state == ST_WRITE)              word_index     <= index_next;
    end
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    state_next = state;
    byte_ready = accepts_bytes(state);
    mem_write  = (state == ST_WRITE);
    done       = (state == ST_DONE);
    error      = (state == ST_ERROR);
    cpu_clear  = (state != ST_DONE);
    case (state)
      ST_LEN_HI: if (accept) state_next = ST_LEN_LO;
      ST_LEN_LO: begin
        if (accept) begin
          if ({1'b0, len_full} > MAX_WORDS) state_next = ST_ERROR;
          else if (len_full == '0)          state_next = ST_AFTER_IMAGE;
          else                              state_next = ST_DATA;
        end
      end
      ST_DATA:  if (word_complete) state_next = ST_WRITE;
      ST_WRITE: state_next = last_word ? ST_AFTER_IMAGE : ST_DATA;
      ST_CHECK: if (accept) state_next = csum_ok ? ST_DONE : ST_ERROR;
      ST_DONE, ST_ERROR: if (start) state_next = ST_LEN_HI;
      default:  state_next = ST_LEN_HI;
    endcase
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: a stream-parsing reference model is
// checked against the DUT every cycle, plus literal end-of-scenario checks.
module tb_imem_loader;

  localparam int AW = 10;
`ifdef LOADER_CHECKSUM_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        clear = 1'b1;
  logic        start = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        byte_ready;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        cpu_clear;
  logic        done;
  logic        error;

  int checks = 0;
  int errors = 0;

  // Writes observed on the memory port.
  int          nw = 0;
  logic [31:0] wa [0:15];
  logic [31:0] wd [0:15];

  // Reference model of the stream parser.
  int          m_pos = 0;
  logic [15:0] m_len = '0;
  int          m_status = 0;   // 0 loading, 1 done, 2 error
  bit          m_wpend = 1'b0;
  bit          m_need_chk = 1'b0;
  int          m_widx = 0;
  logic [31:0] m_word = '0;
  logic [31:0] m_exp_addr = '0;
  logic [31:0] m_exp_data = '0;
  logic [7:0]  m_sum = '0;

  imem_loader #(.ADDR_WIDTH(AW)) dut (
    .clock          (clock),
    .clear          (clear),
    .start          (start),
    .byte_valid     (byte_valid),
    .byte_data      (byte_data),
    .byte_ready     (byte_ready),
    .mem_write      (mem_write),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .cpu_clear      (cpu_clear),
    .done           (done),
    .error          (error)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pos = 0; m_len = '0; m_status = 0; m_wpend = 1'b0; m_need_chk = 1'b0;
    m_widx = 0; m_word = '0; m_sum = '0;
  endtask

  task automatic model_image_end();
    if (CHK) m_need_chk = 1'b1;
    else     m_status = 1;
  endtask

  task automatic model_consume(input logic [7:0] b);
    m_sum = m_sum + b;
    if (m_need_chk) begin
      m_status = (m_sum == 8'h00) ? 1 : 2;
    end else if (m_pos == 0) begin
      m_len[15:8] = b;
    end else if (m_pos == 1) begin
      m_len[7:0] = b;
      if (int'(m_len) > (1 << AW)) m_status = 2;
      else if (m_len == 0)          model_image_end();
    end else begin
      m_word = {m_word[23:0], b};
      if ((m_pos - 2) % 4 == 3) begin
        m_wpend    = 1'b1;
        m_exp_addr = 32'(m_widx * 4);
        m_exp_data = m_word;
      end
    end
    m_pos++;
  endtask

  // Per-cycle comparison against the model, then model advance.
  always @(negedge clock) begin
    if (mem_write && nw < 16) begin
      wa[nw] = mem_address;
      wd[nw] = mem_write_data;
      nw++;
    end
    if (clear) begin
      model_reset();
      chk("rst_ready", 32'(byte_ready), 32'd1);
      chk("rst_write", 32'(mem_write), 32'd0);
      chk("rst_addr", mem_address, 32'd0);
      chk("rst_data", mem_write_data, 32'd0);
      chk("rst_cpu_clear", 32'(cpu_clear), 32'd1);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_error", 32'(error), 32'd0);
    end else begin
      chk("ready", 32'(byte_ready), 32'((m_status == 0) && !m_wpend));
      chk("mem_write", 32'(mem_write), 32'(m_wpend));
      if (m_wpend) begin
        chk("mem_address", mem_address, m_exp_addr);
        chk("mem_write_data", mem_write_data, m_exp_data);
      end
      chk("done", 32'(done), 32'(m_status == 1));
      chk("error", 32'(error), 32'(m_status == 2));
      chk("cpu_clear", 32'(cpu_clear), 32'(m_status != 1));
      if (m_wpend) begin
        m_wpend = 1'b0;
        m_widx++;
        if (m_widx == int'(m_len)) model_image_end();
      end else if (m_status == 0 && byte_valid) begin
        model_consume(byte_data);
      end else if (m_status != 0 && start) begin
        model_reset();
      end
    end
  end

  // Present bytes with the handshake; optionally idle every other cycle.
  task automatic send(input logic [7:0] q[$], input bit toggle);
    int i = 0;
    int cyc = 0;
    bit ph = 1'b0;
    bit acc;
    while (i < q.size() && cyc < 400) begin
      byte_data  = q[i];
      byte_valid = toggle ? ph : 1'b1;
      ph = ~ph;
      @(negedge clock);
      acc = byte_valid && byte_ready;
      @(posedge clock); #1;
      cyc++;
      if (acc) i++;
    end
    byte_valid = 1'b0;
    chk("send_complete", 32'(i), 32'(q.size()));
  endtask

  task automatic wait_finish();
    int cyc = 0;
    while (!(done || error) && cyc < 40) begin
      @(posedge clock); #1;
      cyc++;
    end
    chk("finish_in_time", 32'(done || error), 32'd1);
    @(negedge clock);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    nw = 0;
  endtask

  task automatic expect_prog1();
    chk("p1_nwrites", 32'(nw), 32'd2);
    chk("p1_addr0", wa[0], 32'h0000_0000);
    chk("p1_data0", wd[0], 32'h2008_0005);
    chk("p1_addr1", wa[1], 32'h0000_0004);
    chk("p1_data1", wd[1], 32'h0109_5020);
    chk("p1_done", 32'(done), 32'd1);
    chk("p1_cpu_clear", 32'(cpu_clear), 32'd0);
    chk("p1_error", 32'(error), 32'd0);
  endtask

  logic [7:0] prog1[$];
  logic [7:0] empty[$];
  logic [7:0] toolong[$];
  logic [7:0] partial[$];
  logic [7:0] badsum[$];

  initial begin
    prog1   = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09, 8'h50, 8'h20};
    empty   = '{8'h00, 8'h00};
    toolong = '{8'h04, 8'h01};
    partial = '{8'h00, 8'h02, 8'h20, 8'h08};
    badsum  = prog1;
    if (CHK) begin
      prog1.push_back(8'h57);
      empty.push_back(8'h00);
      badsum.push_back(8'h58);
    end

    repeat (3) @(posedge clock);
    #1 clear = 1'b0;
    nw = 0;

    // Two-word program, continuous stream.
    send(prog1, 1'b0);
    wait_finish();
    expect_prog1();

    // Empty image.
    pulse_start();
    send(empty, 1'b0);
    wait_finish();
    chk("empty_nwrites", 32'(nw), 32'd0);
    chk("empty_done", 32'(done), 32'd1);

    // Length one word past the maximum.
    pulse_start();
    send(toolong, 1'b0);
    wait_finish();
    chk("long_error", 32'(error), 32'd1);
    chk("long_cpu_clear", 32'(cpu_clear), 32'd1);
    chk("long_ready", 32'(byte_ready), 32'd0);
    chk("long_nwrites", 32'(nw), 32'd0);

    // Same program with gaps in byte_valid.
    pulse_start();
    send(prog1, 1'b1);
    wait_finish();
    expect_prog1();

    if (CHK) begin
      pulse_start();
      send(badsum, 1'b0);
      wait_finish();
      chk("badsum_error", 32'(error), 32'd1);
      chk("badsum_done", 32'(done), 32'd0);
      pulse_start();
      send(prog1, 1'b0);
      wait_finish();
      expect_prog1();
    end

    // Abort mid-word with clear, then reload.
    pulse_start();
    send(partial, 1'b0);
    clear = 1'b1;
    @(negedge clock);
    chk("abort_ready", 32'(byte_ready), 32'd1);
    chk("abort_cpu_clear", 32'(cpu_clear), 32'd1);
    chk("abort_data", mem_write_data, 32'd0);
    @(posedge clock); #1;
    clear = 1'b0;
    chk("abort_nwrites", 32'(nw), 32'd0);
    send(prog1, 1'b0);
    wait_finish();
    expect_prog1();

    repeat (2) @(posedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot loader that sits directly upstream of the single-cycle datapath's instruction memory. It receives a program as a byte stream over a valid/ready handshake and assembles big-endian 32-bit words. It writes those words into instruction memory at consecutive word addresses starting at 0. While loading it holds the datapath in clear, and it releases the datapath once the image is complete.

## Interface
Parameters:
- ADDR_WIDTH, 10, word-address width; maximum image is 2**ADDR_WIDTH words.

Ports:
- clock  in  1  system clock; all state changes on rising edge.
- clear  in  1  reset, asynchronous, active-high.
- start  in  1  reload request; honoured only in DONE or ERROR.
- byte_valid  in  1  byte_data is valid this cycle.
- byte_data  in  8  stream byte.
- byte_ready  out  1  loader accepts a byte this cycle.
- mem_write  out  1  instruction-memory write strobe.
- mem_address  out  32  byte address of the word, equal to {word_index, 2'b00} zero-extended.
- mem_write_data  out  32  assembled word.
- cpu_clear  out  1  drives the datapath clear input.
- done  out  1  image loaded successfully.
- error  out  1  image rejected.

## Operation
- Stream format: a 16-bit word count N, sent big-endian (LEN_HI then LEN_LO). Then N×4 data bytes, MSB first per word. Then one checksum byte, present only with the checksum feature compiled in.
- A byte is accepted on a rising edge with byte_valid && byte_ready.
- byte_ready is a combinational function of state only, never of byte_valid. It is 1 in LEN_HI, LEN_LO, DATA and CHECK. It is 0 in WRITE, DONE and ERROR.
- States and transitions:
  - LEN_HI: accept → len[15:8]; go to LEN_LO.
  - LEN_LO: accept → len[7:0].
    - If len > 2**ADDR_WIDTH, go to ERROR.
    - If len == 0, go to CHECK when the checksum feature is compiled in, else DONE.
    - Otherwise go to DATA.
  - DATA: each accepted byte shifts into the word register, and byte_count increments (modulo 4). The 4th accepted byte moves the FSM to WRITE.
  - WRITE: lasts one cycle; mem_write=1; word_index increments at the end of the cycle.
    - If the written word was word N−1, go to CHECK or DONE (as above).
    - Otherwise go back to DATA.
  - CHECK: accept one byte. If the 8-bit sum of all stream bytes, including the length bytes and the checksum byte, equals 0x00, go to DONE; otherwise go to ERROR.
  - DONE: cpu_clear=0, done=1.
  - ERROR: cpu_clear=1, error=1.
- start in DONE or ERROR clears len, word_index, byte_count and the checksum, then goes to LEN_HI. start in any other state has no effect.
- cpu_clear=1 in every state except DONE.
- Arithmetic:
  - word_index is ADDR_WIDTH+1 bits wide.
  - The checksum accumulator is 8 bits and wraps modulo 256.
  - A length of exactly 2**ADDR_WIDTH is legal.

## Timing
- Reset values: state LEN_HI, byte_ready=1, mem_write=0, mem_address=0, mem_write_data=0, cpu_clear=1, done=0, error=0.
- A clear asserted mid-operation aborts immediately, with no partial-word write. Loading restarts from LEN_HI once clear is released.
- mem_write is high for exactly the one cycle after the edge that accepts a word's 4th byte. mem_address and mem_write_data are stable throughout that cycle, and memory captures them on the closing edge.
- Peak throughput is one word per 5 cycles.
- done, error and cpu_clear change on the edge that enters the corresponding state.

## Configuration
- LOADER_CHECKSUM_EN defined: the CHECK state exists, the trailing checksum byte is required, and a mismatch leads to ERROR.
- Macro undefined: no checksum byte is expected; the final WRITE (or LEN_LO when N=0) goes directly to DONE, and the accumulator logic is removed.

## Structure
- Shared package loader_pkg holds:
  - the state encoding constants;
  - LEN_BYTES=2;
  - BYTES_PER_WORD=4.
- One sub-module, loader_word_assembler, contains the 32-bit shift register and the 2-bit byte counter, and outputs word_complete.

## Test plan
- Stream 00 02 20 08 00 05 01 09 50 20 (plus 57 with LOADER_CHECKSUM_EN) → writes addr 0x0 data 0x20080005 and addr 0x4 data 0x01095020, then done=1, cpu_clear=0.
- Stream 00 00 (plus 00 with the checksum feature) → no mem_write, done=1.
- With ADDR_WIDTH=10, stream 04 01 → error=1, cpu_clear=1, byte_ready=0, no writes.
- Same stream as the first scenario with byte_valid toggling every other cycle, and a byte held valid during a WRITE cycle → that byte is not accepted during WRITE, and the written words are identical to the first scenario.
- With LOADER_CHECKSUM_EN, first-scenario stream with checksum byte 58 → error=1. Pulse start and resend the correct stream → done=1.
- Assert clear after two data bytes → all outputs return to reset values, with no write. The full first-scenario stream then completes normally.
